// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Requester-side bundle of one memory port of mem_port_arbiter.
//   The requester drives a command (req/we/addr/wdata) and holds it until
//   gnt is seen high. Read data returns later as a one-cycle rvalid pulse,
//   and rdata holds its value until the next read response.
//
//   Signals:
//     req    requester -> arbiter  request, held with command until granted
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  byte address (passed through unmodified)
//     wdata  requester -> arbiter  write data
//     gnt    arbiter -> requester  command accepted this cycle (combinational)
//     rvalid arbiter -> requester  read data valid, one-cycle pulse
//     rdata  arbiter -> requester  read data, held until next read response
//
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory with a combinational read path between
//   two requesters. Three stages:
//     arbitration - combinational grant, at most one port per cycle
//     command     - registers the winning command and drives the memory
//     response    - registers read data into the owning port, rvalid pulse
//   Accept-to-rvalid latency is 2 cycles; total throughput 1 access/cycle.
//
//   Parameters:
//     ADDR_W  address width
//     DATA_W  data width
//     RR_EN   1 = round-robin, 0 = fixed priority (port 0 always wins)
//
//   Ports:
//     clk               system clock, all state on posedge
//     rst_n             synchronous active-low reset
//     p0, p1            requester ports (mem_port_arbiter_if.slave)
//     o_mem_write       memory write strobe
//     o_mem_address     memory address
//     o_mem_write_data  memory write data
//     i_mem_read_data   memory read data (combinational read)
//     o_p0_gnt_cnt,
//     o_p1_gnt_cnt      16-bit wrapping accept counters, only present when
//                       the macro ARB_GRANT_CNT_EN is defined
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave p0,
  mem_port_arbiter_if.slave p1,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  input  logic [DATA_W-1:0] i_mem_read_data
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]       o_p0_gnt_cnt,
  output logic [15:0]       o_p1_gnt_cnt
`endif
);

  // Round-robin pointer: 0 = port 0 has priority, 1 = port 1 has priority.
  logic              r_rr_ptr;

  logic              r_cmd_valid;
  logic              r_cmd_we;
  logic              r_cmd_port;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;

  logic              r_p0_rvalid;
  logic              r_p1_rvalid;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  logic              w_p0_wins;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_rd_p0;
  logic              w_rd_p1;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_p0_wins = 1'b1;
    if (RR_EN) begin
      w_p0_wins = ~r_rr_ptr;
    end
    w_gnt0 = rst_n & p0.req & (~p1.req | w_p0_wins);
    w_gnt1 = rst_n & p1.req & ~w_gnt0;
  end

  assign w_accept    = w_gnt0 | w_gnt1;
  assign w_sel_we    = w_gnt0 ? p0.we    : p1.we;
  assign w_sel_addr  = w_gnt0 ? p0.addr  : p1.addr;
  assign w_sel_wdata = w_gnt0 ? p0.wdata : p1.wdata;

  // Read in the command stage: its data is captured for the owning port at
  // the end of this cycle, so rvalid appears the following cycle.
  assign w_rd_p0 = r_cmd_valid & ~r_cmd_we & ~r_cmd_port;
  assign w_rd_p1 = r_cmd_valid & ~r_cmd_we &  r_cmd_port;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_port  <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_cmd_valid <= w_accept;
      // Address/data hold their last values when nothing is accepted.
      if (w_accept) begin
        r_cmd_we    <= w_sel_we;
        r_cmd_port  <= w_gnt1;
        r_cmd_addr  <= w_sel_addr;
        r_cmd_wdata <= w_sel_wdata;
        // After any grant the other port gets priority.
        r_rr_ptr    <= w_gnt0;
      end
      r_p0_rvalid <= w_rd_p0;
      r_p1_rvalid <= w_rd_p1;
      if (w_rd_p0) begin
        r_p0_rdata <= i_mem_read_data;
      end
      if (w_rd_p1) begin
        r_p1_rdata <= i_mem_read_data;
      end
    end
  end

  assign p0.gnt    = w_gnt0;
  assign p1.gnt    = w_gnt1;
  assign p0.rvalid = r_p0_rvalid;
  assign p1.rvalid = r_p1_rvalid;
  assign p0.rdata  = r_p0_rdata;
  assign p1.rdata  = r_p1_rdata;

  // rst_n is folded in so a write sitting in the command stage while reset
  // is asserted never reaches the memory.
  assign o_mem_write      = r_cmd_valid & r_cmd_we & rst_n;
  assign o_mem_address    = r_cmd_addr;
  assign o_mem_write_data = r_cmd_wdata;

`ifdef ARB_GRANT_CNT_EN
  logic [15:0] r_p0_gnt_cnt;
  logic [15:0] r_p1_gnt_cnt;

  // Counters wrap naturally from 16'hFFFF to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p0_gnt_cnt <= '0;
      r_p1_gnt_cnt <= '0;
    end else begin
      if (w_gnt0) begin
        r_p0_gnt_cnt <= r_p0_gnt_cnt + 16'd1;
      end
      if (w_gnt1) begin
        r_p1_gnt_cnt <= r_p1_gnt_cnt + 16'd1;
      end
    end
  end

  assign o_p0_gnt_cnt = r_p0_gnt_cnt;
  assign o_p1_gnt_cnt = r_p1_gnt_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A round-robin instance is
//   connected to a behavioural async memory; a second, fixed-priority
//   instance only has its grants observed. Read responses are checked by a
//   scoreboard fed from a reference memory updated in accept order.
//   Optional counter checks follow the macro ARB_GRANT_CNT_EN.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic init_mem;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f0_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f1_if ();

  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          fp_mem_write;
  logic [AW-1:0] fp_mem_address;
  logic [DW-1:0] fp_mem_write_data;
  logic [DW-1:0] fp_mem_read_data;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] p0_cnt, p1_cnt, fp0_cnt, fp1_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .p0               (p0_if),
    .p1               (p1_if),
    .o_mem_write      (mem_write),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_write_data),
    .i_mem_read_data  (mem_read_data)
`ifdef ARB_GRANT_CNT_EN
    ,
    .o_p0_gnt_cnt     (p0_cnt),
    .o_p1_gnt_cnt     (p1_cnt)
`endif
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) u_dut_fp (
    .clk              (clk),
    .rst_n            (rst_n),
    .p0               (f0_if),
    .p1               (f1_if),
    .o_mem_write      (fp_mem_write),
    .o_mem_address    (fp_mem_address),
    .o_mem_write_data (fp_mem_write_data),
    .i_mem_read_data  (fp_mem_read_data)
`ifdef ARB_GRANT_CNT_EN
    ,
    .o_p0_gnt_cnt     (fp0_cnt),
    .o_p1_gnt_cnt     (fp1_cnt)
`endif
  );

  assign fp_mem_read_data = fp_mem_address ^ fp_mem_write_data;

  // Behavioural async memory: 64 words, word index from address bits [7:2].
  logic [DW-1:0] tb_mem [0:63];
  assign mem_read_data = tb_mem[mem_address[7:2]];

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA5A5_0000 + i;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_val(i);
    end else if (mem_write) begin
      tb_mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] ref_mem [0:63];

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        eg0, eg1, emw;
    logic [31:0] ema, ewd;
  } vec_t;

  vec_t vecs [15];

  task automatic drive_p0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d;
  endtask

  task automatic drive_p1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d;
  endtask

  initial begin
    exp_t          e;
    logic [DW-1:0] saved;

    rst_n    = 1'b0;
    init_mem = 1'b1;
    drive_p0(1'b1, 1'b0, 32'h0, 32'h0);   // request held during reset must not be granted
    drive_p1(1'b0, 1'b0, 32'h0, 32'h0);
    f0_if.req = 1'b0; f0_if.we = 1'b0; f0_if.addr = '0; f0_if.wdata = '0;
    f1_if.req = 1'b0; f1_if.we = 1'b0; f1_if.addr = '0; f1_if.wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

    //            r0 w0 a0        d0            r1 w1 a1      d1            g0 g1 mw ma        wd
    vecs[0]  = '{1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0};
    vecs[1]  = '{1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b0,32'h00,32'h0};
    vecs[2]  = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b1,32'h10,32'hDEADBEEF};
    vecs[3]  = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h08,32'h0,        1'b0,1'b1,1'b0,32'h10,32'h0};
    vecs[4]  = '{1'b1,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h04,32'h0,        1'b1,1'b0,1'b0,32'h08,32'h0};
    vecs[5]  = '{1'b1,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h04,32'h0,        1'b0,1'b1,1'b0,32'h00,32'h0};
    vecs[6]  = '{1'b1,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h04,32'h0,        1'b1,1'b0,1'b0,32'h04,32'h0};
    vecs[7]  = '{1'b1,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h04,32'h0,        1'b0,1'b1,1'b0,32'h00,32'h0};
    vecs[8]  = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b1,32'h20,32'h12345678, 1'b0,1'b1,1'b0,32'h04,32'h0};
    vecs[9]  = '{1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b1,32'h20,32'h12345678};
    vecs[10] = '{1'b1,1'b1,32'h24,32'hCAFEF00D, 1'b1,1'b0,32'h24,32'h0,        1'b0,1'b1,1'b0,32'h20,32'h0};
    vecs[11] = '{1'b1,1'b1,32'h24,32'hCAFEF00D, 1'b1,1'b0,32'h24,32'h0,        1'b1,1'b0,1'b0,32'h24,32'h0};
    vecs[12] = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h24,32'h0,        1'b0,1'b1,1'b1,32'h24,32'hCAFEF00D};
    vecs[13] = '{1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h24,32'h0};
    vecs[14] = '{1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h24,32'h0};

    // Scoreboard monitor: checks responses, records accepts into the model.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q0.delete();
          q1.delete();
        end else begin
          chk("gnt_onehot", {31'b0, p0_if.gnt & p1_if.gnt}, 32'h0);
          if (p0_if.rvalid) begin
            if (q0.size() == 0) chk("p0_unexpected_rvalid", 32'h1, 32'h0);
            else begin
              e = q0.pop_front();
              chk("p0_rdata", p0_if.rdata, e.data);
              chk("p0_latency", cyc, e.cyc + 2);
            end
          end
          if (p1_if.rvalid) begin
            if (q1.size() == 0) chk("p1_unexpected_rvalid", 32'h1, 32'h0);
            else begin
              e = q1.pop_front();
              chk("p1_rdata", p1_if.rdata, e.data);
              chk("p1_latency", cyc, e.cyc + 2);
            end
          end
          if (p0_if.req && p0_if.gnt) begin
            if (p0_if.we) ref_mem[p0_if.addr[7:2]] = p0_if.wdata;
            else q0.push_back('{ref_mem[p0_if.addr[7:2]], cyc});
          end
          if (p1_if.req && p1_if.gnt) begin
            if (p1_if.we) ref_mem[p1_if.addr[7:2]] = p1_if.wdata;
            else q1.push_back('{ref_mem[p1_if.addr[7:2]], cyc});
          end
        end
      end
    join_none

    // Reset, then idle.
    @(negedge clk);
    chk("reset_gnt_forced0", {31'b0, p0_if.gnt}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    init_mem = 1'b0;
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_p0_gnt", {31'b0, p0_if.gnt}, 32'h0);
    chk("idle_p1_gnt", {31'b0, p1_if.gnt}, 32'h0);
    chk("idle_p0_rvalid", {31'b0, p0_if.rvalid}, 32'h0);
    chk("idle_p1_rvalid", {31'b0, p1_if.rvalid}, 32'h0);
    chk("idle_mem_write", {31'b0, mem_write}, 32'h0);
    chk("idle_mem_address", mem_address, 32'h0);
    chk("idle_p0_rdata", p0_if.rdata, 32'h0);
    chk("idle_p1_rdata", p1_if.rdata, 32'h0);

    // Table-driven: write/read, RR contention, cross-port RAW, same-address hazard.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      drive_p0(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
      drive_p1(vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      $display("vec %0d: gnt0=%0b gnt1=%0b mem_write=%0b mem_address=%h", i,
               p0_if.gnt, p1_if.gnt, mem_write, mem_address);
      chk($sformatf("vec%0d_gnt0", i), {31'b0, p0_if.gnt}, {31'b0, vecs[i].eg0});
      chk($sformatf("vec%0d_gnt1", i), {31'b0, p1_if.gnt}, {31'b0, vecs[i].eg1});
      chk($sformatf("vec%0d_mem_write", i), {31'b0, mem_write}, {31'b0, vecs[i].emw});
      chk($sformatf("vec%0d_mem_address", i), mem_address, vecs[i].ema);
      if (vecs[i].emw) chk($sformatf("vec%0d_mem_wdata", i), mem_write_data, vecs[i].ewd);
    end
    repeat (3) @(negedge clk);
    chk("drain_q0", q0.size(), 32'h0);
    chk("drain_q1", q1.size(), 32'h0);
`ifdef ARB_GRANT_CNT_EN
    chk("p0_gnt_cnt_total", {16'b0, p0_cnt}, 32'd6);
    chk("p1_gnt_cnt_total", {16'b0, p1_cnt}, 32'd6);
`endif

    // Fixed priority: port 1 starves while port 0 requests.
    @(posedge clk);
    #1;
    f0_if.req = 1'b1; f0_if.addr = 32'h40;
    f1_if.req = 1'b1; f1_if.addr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("fp cycle %0d: gnt0=%0b gnt1=%0b", i, f0_if.gnt, f1_if.gnt);
      chk($sformatf("fp%0d_gnt0", i), {31'b0, f0_if.gnt}, 32'h1);
      chk($sformatf("fp%0d_gnt1", i), {31'b0, f1_if.gnt}, 32'h0);
      @(posedge clk);
      #1;
    end
    f0_if.req = 1'b0;
    @(negedge clk);
    chk("fp_p1_after_drop", {31'b0, f1_if.gnt}, 32'h1);
    chk("fp_mem_write", {31'b0, fp_mem_write}, 32'h0);
    @(posedge clk);
    #1;
    f1_if.req = 1'b0;

    // Fresh reset, then a write killed by reset in its command cycle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saved = ref_mem[4];
    drive_p0(1'b1, 1'b1, 32'h10, 32'h0BADF00D);
    @(negedge clk);
    chk("midrst_wr_gnt", {31'b0, p0_if.gnt}, 32'h1);
    @(posedge clk);
    #1;
`ifdef ARB_GRANT_CNT_EN
    chk("midrst_cnt_one", {16'b0, p0_cnt}, 32'd1);
`endif
    rst_n = 1'b0;
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midrst_mem_write_suppressed", {31'b0, mem_write}, 32'h0);
    ref_mem[4] = saved;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
`ifdef ARB_GRANT_CNT_EN
    chk("midrst_cnt0_cleared", {16'b0, p0_cnt}, 32'd0);
    chk("midrst_cnt1_cleared", {16'b0, p1_cnt}, 32'd0);
`endif
    chk("midrst_rvalid0", {31'b0, p0_if.rvalid}, 32'h0);
    @(posedge clk);
    #1;
    drive_p0(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("midrst_rd_gnt", {31'b0, p0_if.gnt}, 32'h1);
    @(posedge clk);
    #1;
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("final_q0", q0.size(), 32'h0);
    chk("final_q1", q1.size(), 32'h0);
    chk("final_p0_rdata", p0_if.rdata, saved);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
